cronos_ctrl: RTL and testbench

Pushbutton front-end and run-control state machine for the stopwatch. It sits directly upstream of the chronometer counting chain and digit multiplexer, and consumes two raw board buttons. It produces the count enable and clear for the seconds/minutes counters, plus a lap-freeze view of the 4-digit BCD time that feeds the display mux. All outputs are registered in the `osc_clk` domain.

---
 rtl/cronos_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cronos_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cronos_ctrl.sv
// Stopwatch run-control front end: two debounced pushbuttons drive a
// four-state run FSM and a lap-freeze register for the BCD display path.
// Every output is registered in the osc_clk domain.
module cronos_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        osc_clk,
  input  logic        reset,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic [15:0] time_bcd,
  output logic        run,
  output logic        clr,
  output logic        frozen,
  output logic [15:0] disp_bcd
);

  // Counter value at which a persistent difference is accepted as a new level.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StLap  = 2'd2;
  localparam logic [1:0] StStop = 2'd3;

  localparam int unsigned NumBtn = 2;
  localparam int unsigned BtnSs  = 0;
  localparam int unsigned BtnLap = 1;

  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q;
  logic [NumBtn-1:0] sync2_q;
  logic [NumBtn-1:0] stable_q;
  logic [NumBtn-1:0] stable_d;
  logic [NumBtn-1:0] stable_dly_q;
  logic [NumBtn-1:0] press_q;
  logic [CNT_W-1:0]  cnt_q [NumBtn];
  logic [CNT_W-1:0]  cnt_d [NumBtn];

  logic        ss_p;
  logic        lap_p;
  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic        clr_d;
  logic        run_q;
  logic        clr_q;
  logic        frozen_q;
  logic [15:0] disp_q;
  logic [15:0] disp_d;

  assign btn_raw = {btn_lap, btn_ss};

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive differing samples; any agreeing sample restarts the count.
  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      cnt_d[i]    = '0;
      stable_d[i] = stable_q[i];
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debouncer stable levels and counters.
  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      stable_q <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // One-cycle press pulse on each debounced rising edge; releases are ignored.
  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      stable_dly_q <= '0;
      press_q      <= '0;
    end else begin
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
    end
  end

  assign ss_p  = press_q[BtnSs];
  assign lap_p = press_q[BtnLap];

  // Run-control next state; start/stop has priority over lap/clear.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (ss_p) begin
          state_d = StRun;
        end else if (lap_p) begin
          clr_d = 1'b1;
        end
      end
      StRun: begin
        if (ss_p) begin
          state_d = StStop;
        end else if (lap_p) begin
          state_d = StLap;
        end
      end
      StLap: begin
        if (ss_p) begin
          state_d = StStop;
        end else if (lap_p) begin
          state_d = StRun;
        end
      end
      StStop: begin
        if (ss_p) begin
          state_d = StRun;
        end else if (lap_p) begin
          state_d = StIdle;
          clr_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Display: hold only while staying in LAP; entering LAP captures the live value.
  always_comb begin
    if ((state_d == StLap) && (state_q == StLap)) begin
      disp_d = disp_q;
    end else begin
      disp_d = time_bcd;
    end
  end

  // State and registered outputs, decoded from the next state so they move together.
  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      run_q    <= 1'b0;
      clr_q    <= 1'b0;
      frozen_q <= 1'b0;
      disp_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      run_q    <= (state_d == StRun) || (state_d == StLap);
      clr_q    <= clr_d;
      frozen_q <= (state_d == StLap);
      disp_q   <= disp_d;
    end
  end

  assign run      = run_q;
  assign clr      = clr_q;
  assign frozen   = frozen_q;
  assign disp_bcd = disp_q;

endmodule

// File: tb/tb_cronos_ctrl.sv
// Directed bench for cronos_ctrl with DEBOUNCE_CYCLES=4; display values are
// scoreboarded through a queue, control outputs checked at fixed latencies.
module tb_cronos_ctrl;

  localparam int unsigned Deb = 4;

  logic        osc_clk = 1'b0;
  logic        reset;
  logic        btn_ss;
  logic        btn_lap;
  logic [15:0] time_bcd;
  logic        run;
  logic        clr;
  logic        frozen;
  logic [15:0] disp_bcd;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb [$];
  logic [15:0] live;
  logic [15:0] adv [8];

  cronos_ctrl #(
    .DEBOUNCE_CYCLES(Deb),
    .CNT_W          (4)
  ) dut (
    .osc_clk (osc_clk),
    .reset   (reset),
    .btn_ss  (btn_ss),
    .btn_lap (btn_lap),
    .time_bcd(time_bcd),
    .run     (run),
    .clr     (clr),
    .frozen  (frozen),
    .disp_bcd(disp_bcd)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 ns later, retire one pending display expectation.
  task automatic tick();
    logic [15:0] e;
    @(posedge osc_clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("disp_bcd", disp_bcd, e);
    end
  endtask

  task automatic step(input logic [15:0] t, input logic [15:0] e);
    time_bcd = t;
    sb.push_back(e);
    tick();
  endtask

  task automatic live_step();
    live = live + 16'h0001;
    step(live, live);
  endtask

  initial begin
    adv = '{16'h0124, 16'h0125, 16'h0126, 16'h0127,
            16'h0128, 16'h0129, 16'h0130, 16'h0130};
    reset    = 1'b0;
    btn_ss   = 1'b0;
    btn_lap  = 1'b0;
    time_bcd = 16'h0000;
    live     = 16'h0100;

    // Reset values
    repeat (2) tick();
    time_bcd = 16'hBEEF;
    tick();
    check("rst_run", 16'(run), 16'h0);
    check("rst_clr", 16'(clr), 16'h0);
    check("rst_frozen", 16'(frozen), 16'h0);
    check("rst_disp", disp_bcd, 16'h0000);
    reset = 1'b1;
    repeat (2) live_step();
    check("idle_run", 16'(run), 16'h0);

    // Clean start: run rises on the 8th edge after the raw rise
    btn_ss = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      live_step();
      check("start_run", 16'(run), 16'(k == 8));
    end
    check("start_frozen", 16'(frozen), 16'h0);
    check("start_clr", 16'(clr), 16'h0);
    btn_ss = 1'b0;
    repeat (8) live_step();
    check("run_after_release", 16'(run), 16'h1);

    // Lap capture of 0123
    btn_lap = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(16'h0123, 16'h0123);
      check("lap_clr", 16'(clr), 16'h0);
      check("lap_frozen", 16'(frozen), 16'(k == 8));
    end
    check("lap_run", 16'(run), 16'h1);
    btn_lap = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(adv[i], 16'h0123);
      check("lap_hold_frozen", 16'(frozen), 16'h1);
    end
    check("lap_hold_run", 16'(run), 16'h1);

    // Second lap press unfreezes; display live again
    btn_lap = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k < 8) step(16'h0130, 16'h0123);
      else       step(16'h0131, 16'h0131);
      check("unlap_frozen", 16'(frozen), 16'(k < 8));
      check("unlap_clr", 16'(clr), 16'h0);
    end
    check("unlap_run", 16'(run), 16'h1);
    btn_lap = 1'b0;
    live    = 16'h0131;
    repeat (8) live_step();

    // Simultaneous press in RUN: start/stop wins
    btn_ss  = 1'b1;
    btn_lap = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      live_step();
      check("simul_run", 16'(run), 16'(k < 8));
      check("simul_clr", 16'(clr), 16'h0);
    end
    check("simul_frozen", 16'(frozen), 16'h0);
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (8) live_step();
    check("stop_run", 16'(run), 16'h0);

    // Clear from STOP, then again from IDLE
    for (int p = 0; p < 2; p++) begin
      btn_lap = 1'b1;
      for (int k = 1; k <= 9; k++) begin
        live_step();
        check(p == 0 ? "clr_stop" : "clr_idle", 16'(clr), 16'(k == 8));
        check("clr_run", 16'(run), 16'h0);
      end
      btn_lap = 1'b0;
      repeat (8) live_step();
      check("clr_after", 16'(clr), 16'h0);
    end

    // Bounce 1,0,1,0 then hold: one press, 8 cycles after the final rise
    btn_ss = 1'b1; live_step();
    btn_ss = 1'b0; live_step();
    btn_ss = 1'b1; live_step();
    btn_ss = 1'b0; live_step();
    btn_ss = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      live_step();
      check("bounce_run", 16'(run), 16'(k == 8));
    end
    btn_ss = 1'b0;
    repeat (8) live_step();

    // 3-cycle glitch is rejected
    btn_ss = 1'b1;
    repeat (3) live_step();
    btn_ss = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      live_step();
      check("glitch_run", 16'(run), 16'h1);
    end

    // Held stop press yields a single event
    btn_ss = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      live_step();
      check("hold_run", 16'(run), 16'(k < 8));
    end
    btn_ss = 1'b0;
    repeat (8) live_step();

    // Restart, then asynchronous reset mid-RUN
    btn_ss = 1'b1;
    repeat (8) live_step();
    check("restart_run", 16'(run), 16'h1);
    btn_ss = 1'b0;
    repeat (8) live_step();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_run", 16'(run), 16'h0);
    check("async_rst_clr", 16'(clr), 16'h0);
    check("async_rst_frozen", 16'(frozen), 16'h0);
    check("async_rst_disp", disp_bcd, 16'h0000);
    btn_ss = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      live_step();
      check("held_thru_rst_run", 16'(run), 16'(k == 8));
    end
    btn_ss = 1'b0;
    repeat (2) live_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
